// File: rtl/regfile_multi.sv
// Multi-port register file with write bypass and a per-register busy
// scoreboard for read-after-write hazard detection.
module regfile_multi #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic              busy_set,
  input  logic [AW-1:0]     busy_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic              any_busy
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wr_ok;

  assign wr_ok = we && !(ZERO_REG != 0 && waddr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // A new producer supersedes the one completing on the same edge.
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < NREGS; r++) begin
      if (busy_set && busy_addr == AW'(r))
        busy_nxt[r] = 1'b1;
      else if (we && waddr == AW'(r))
        busy_nxt[r] = 1'b0;
    end
    if (ZERO_REG != 0)
      busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign any_busy = |busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          zero;
    logic          byp;

    assign ra   = raddr[i*AW +: AW];
    assign zero = (ZERO_REG != 0) && (ra == '0);
    assign byp  = (BYPASS != 0) && we && (waddr == ra);

    // Outputs are held at zero while reset is asserted, bypass included.
    assign rdata[i*XLEN +: XLEN] =
      (!rst_n || zero) ? '0    :
      byp              ? wdata :
                         regs[ra];

    assign rd_busy[i] = rst_n && !zero && !byp && busy[ra];
  end

endmodule

// File: tb/tb_regfile_multi.sv
// Directed bench for regfile_multi: a default build (2 ports, zero reg,
// bypass) and a 4-port build without zero reg or bypass, driven in lockstep.
module tb_regfile_multi;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         we;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic         busy_set;
  logic [4:0]   busy_addr;

  logic [9:0]   a_raddr;
  logic [63:0]  a_rdata;
  logic [1:0]   a_rd_busy;
  logic         a_any_busy;

  logic [19:0]  b_raddr;
  logic [127:0] b_rdata;
  logic [3:0]   b_rd_busy;
  logic         b_any_busy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_multi dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(a_raddr), .rdata(a_rdata), .busy_set(busy_set),
    .busy_addr(busy_addr), .rd_busy(a_rd_busy), .any_busy(a_any_busy)
  );

  regfile_multi #(
    .NRD(4), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(b_raddr), .rdata(b_rdata), .busy_set(busy_set),
    .busy_addr(busy_addr), .rd_busy(b_rd_busy), .any_busy(b_any_busy)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b1; waddr = 5'd1; wdata = 32'hFF;
    busy_set = 1'b1; busy_addr = 5'd1;
    a_raddr = {5'd1, 5'd1};
    b_raddr = {4{5'd1}};
    nxt(); #1;
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_a_rd_busy", a_rd_busy, 0);
    chk("rst_a_any", a_any_busy, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_b_any", b_any_busy, 0);

    nxt();
    rst_n = 1'b1; we = 1'b0; busy_set = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) begin
      a_raddr = {5'(r), 5'(r)};
      b_raddr = {4{5'(r)}};
      #1;
      chk("clr_a", {a_rd_busy, a_rdata}, 0);
      chk("clr_b", {b_rd_busy, b_rdata}, 0);
    end
    chk("clr_any", {a_any_busy, b_any_busy}, 0);

    // Same-cycle write/read of register 5
    nxt();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    a_raddr = {5'd0, 5'd5}; b_raddr = {15'd0, 5'd5};
    #1;
    chk("byp_a", a_rdata[31:0], 32'hDEADBEEF);
    chk("nobyp_b", b_rdata[31:0], 0);
    nxt(); we = 1'b0; #1;
    chk("wr5_a", a_rdata[31:0], 32'hDEADBEEF);
    chk("wr5_b", b_rdata[31:0], 32'hDEADBEEF);

    // Register 0 write and busy set
    nxt();
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    busy_set = 1'b1; busy_addr = 5'd0;
    a_raddr = 0; b_raddr = 0;
    #1;
    chk("r0_a_same", a_rdata[31:0], 0);
    chk("r0_b_same", b_rdata[31:0], 0);
    nxt(); we = 1'b0; busy_set = 1'b0; #1;
    chk("r0_a_data", a_rdata[31:0], 0);
    chk("r0_a_busy", a_rd_busy[0], 0);
    chk("r0_a_any", a_any_busy, 0);
    chk("r0_b_data", b_rdata[31:0], 32'h12345678);
    chk("r0_b_busy", b_rd_busy[0], 1);
    chk("r0_b_any", b_any_busy, 1);
    nxt(); we = 1'b1; #1;
    chk("r0_b_busy_wr", b_rd_busy[0], 1);
    nxt(); we = 1'b0; #1;
    chk("r0_b_busy_clr", b_rd_busy[0], 0);
    chk("r0_b_any_clr", b_any_busy, 0);

    // Busy on register 7, later satisfied by a write
    nxt();
    busy_set = 1'b1; busy_addr = 5'd7;
    a_raddr = {5'd7, 5'd0}; b_raddr = {10'd0, 5'd7, 5'd0};
    #1;
    chk("b7_pre", a_rd_busy[1], 0);
    nxt(); busy_set = 1'b0; #1;
    chk("b7_set_a", a_rd_busy[1], 1);
    chk("b7_any_a", a_any_busy, 1);
    chk("b7_set_b", b_rd_busy[1], 1);
    nxt(); nxt();
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5;
    #1;
    chk("b7_wr_a_busy", a_rd_busy[1], 0);
    chk("b7_wr_a_data", a_rdata[63:32], 32'hA5);
    chk("b7_wr_b_busy", b_rd_busy[1], 1);
    chk("b7_wr_b_data", b_rdata[63:32], 0);
    nxt(); we = 1'b0; #1;
    chk("b7_done_a", {a_any_busy, a_rd_busy[1], a_rdata[63:32]},
        {2'b00, 32'hA5});
    chk("b7_done_b", {b_rd_busy[1], b_rdata[63:32]}, {1'b0, 32'hA5});

    // Set and write of register 3 on the same edge, then async reset
    nxt();
    busy_set = 1'b1; busy_addr = 5'd3;
    we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    a_raddr = {5'd0, 5'd3}; b_raddr = {15'd0, 5'd3};
    #1;
    chk("s3_a_data", a_rdata[31:0], 32'h11);
    chk("s3_a_busy", a_rd_busy[0], 0);
    nxt(); we = 1'b0; busy_set = 1'b0; #1;
    chk("s3_a_after", {a_any_busy, a_rd_busy[0], a_rdata[31:0]},
        {2'b11, 32'h11});
    chk("s3_b_after", {b_any_busy, b_rd_busy[0], b_rdata[31:0]},
        {2'b11, 32'h11});
    #1 rst_n = 1'b0;
    #1;
    chk("arst_a", {a_any_busy, a_rd_busy, a_rdata}, 0);
    chk("arst_b", {b_any_busy, b_rd_busy, b_rdata}, 0);
    nxt(); rst_n = 1'b1; #1;
    chk("arst_a_rel", a_rdata[31:0], 0);
    chk("arst_b_rel", b_rdata[31:0], 0);

    // All read ports on register 9
    nxt();
    we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    a_raddr = {2{5'd9}}; b_raddr = {4{5'd9}};
    nxt(); we = 1'b0; busy_set = 1'b1; busy_addr = 5'd9; #1;
    chk("r9_b_data", b_rdata, {4{32'h55}});
    chk("r9_a_data", a_rdata, {2{32'h55}});
    chk("r9_b_idle", b_rd_busy, 4'h0);
    nxt(); busy_set = 1'b0; #1;
    chk("r9_b_busy", b_rd_busy, 4'hF);
    chk("r9_a_busy", a_rd_busy, 2'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
